dmem_rd_arbiter: RTL

- Shares the single data-memory read port between two requesters:
  - the load/store unit (LSU) in the mem stage;
  - the atomic-sequence read path (AMO read enable, address and length from the AMO unit).
- Sits between the core pipeline and the data-memory interface.
- Serialises reads with one outstanding transaction, routes the returned data-valid strobe to the owning requester, drops results of flushed LSU reads, and recovers from a hung memory with a watchdog.

---
 rtl/dmem_rd_arbiter_pkg.sv | 25 ++
 rtl/dmem_rd_arbiter_if.sv | 39 +++
 rtl/dmem_rd_watchdog.sv | 34 +++
 rtl/dmem_rd_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/dmem_rd_arbiter_pkg.sv
// Shared definitions for the data-memory read arbiter.
// Holds the FSM state and owner encodings and the read-length codes
// that the core uses for data-memory accesses.
package dmem_rd_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_ISSUE    = 3'd1,
    ARB_BUSY_LSU = 3'd2,
    ARB_BUSY_AMO = 3'd3,
    ARB_DRAIN    = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWNER_LSU = 1'b0,
    OWNER_AMO = 1'b1
  } owner_t;

  // Read-length codes shared with the LSU and AMO unit.
  localparam logic [1:0] RLEN_BYTE  = 2'b00;
  localparam logic [1:0] RLEN_HALF  = 2'b01;
  localparam logic [1:0] RLEN_WORD  = 2'b10;
  localparam logic [1:0] RLEN_DWORD = 2'b11;

endpackage

// File: rtl/dmem_rd_arbiter_if.sv
// Bundle of requester and memory-side signals around the read arbiter.
// slave  : arbiter side (takes requests and memory response, drives
//          grants, routed data-valid strobes, memory strobe and bus_err).
// master : environment side (LSU, AMO unit and data memory).
interface dmem_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int RLEN_W = 2
);
  logic              lsu_req;
  logic [ADDR_W-1:0] lsu_addr;
  logic [RLEN_W-1:0] lsu_rlen;
  logic              lsu_flush;
  logic              lsu_grant;
  logic              lsu_rdata_valid;
  logic              amo_req;
  logic [ADDR_W-1:0] amo_addr;
  logic [RLEN_W-1:0] amo_rlen;
  logic              amo_grant;
  logic              amo_rdata_valid;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [RLEN_W-1:0] mem_rlen;
  logic              mem_rdata_valid;
  logic              bus_err;

  modport slave (
    input  lsu_req, lsu_addr, lsu_rlen, lsu_flush,
    input  amo_req, amo_addr, amo_rlen, mem_rdata_valid,
    output lsu_grant, lsu_rdata_valid, amo_grant, amo_rdata_valid,
    output mem_ren, mem_addr, mem_rlen, bus_err
  );

  modport master (
    output lsu_req, lsu_addr, lsu_rlen, lsu_flush,
    output amo_req, amo_addr, amo_rlen, mem_rdata_valid,
    input  lsu_grant, lsu_rdata_valid, amo_grant, amo_rdata_valid,
    input  mem_ren, mem_addr, mem_rlen, bus_err
  );
endinterface

// File: rtl/dmem_rd_watchdog.sv
// Transaction watchdog for the read arbiter.
// Ports: clk, rstn (async active-low), clr_i (zero the count),
//        en_i (count this cycle), expire_o (count has reached TIMEOUT
//        while enabled; combinational, one cycle since the FSM leaves
//        the waiting states on it).
module dmem_rd_watchdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // The count is 0 in the first waiting cycle, so expiry lands exactly
  // TIMEOUT cycles after the transaction starts waiting.
  assign expire_o = en_i && (cnt_q == LIMIT);
endmodule

// File: rtl/dmem_rd_arbiter.sv
// Data-memory read-port arbiter between the LSU and the AMO read path.
// One outstanding read; fixed priority AMO > LSU; grants only in IDLE.
// Ports: clk, rstn (async active-low), bus (dmem_rd_arbiter_if.slave)
//        carrying requests/grants, routed data-valid strobes, the memory
//        read strobe/address/length, memory data-valid and bus_err.
module dmem_rd_arbiter
  import dmem_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int RLEN_W  = 2,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  dmem_rd_arbiter_if.slave     bus
);
  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RLEN_W-1:0] rlen_q, rlen_d;
  logic              wd_clr, wd_en, wd_expire;

  dmem_rd_watchdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_LSU;
      addr_q  <= '0;
      rlen_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rlen_q  <= rlen_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    addr_d              = addr_q;
    rlen_d              = rlen_q;
    wd_clr              = 1'b0;
    wd_en               = 1'b0;
    bus.lsu_grant       = 1'b0;
    bus.amo_grant       = 1'b0;
    bus.lsu_rdata_valid = 1'b0;
    bus.amo_rdata_valid = 1'b0;
    bus.mem_ren         = 1'b0;
    bus.bus_err         = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (bus.amo_req) begin
          bus.amo_grant = 1'b1;
          owner_d       = OWNER_AMO;
          addr_d        = bus.amo_addr;
          rlen_d        = bus.amo_rlen;
          wd_clr        = 1'b1;
          state_d       = ARB_ISSUE;
        end else if (bus.lsu_req && !bus.lsu_flush) begin
          bus.lsu_grant = 1'b1;
          owner_d       = OWNER_LSU;
          addr_d        = bus.lsu_addr;
          rlen_d        = bus.lsu_rlen;
          wd_clr        = 1'b1;
          state_d       = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        bus.mem_ren = 1'b1;
        if (owner_q == OWNER_AMO) state_d = ARB_BUSY_AMO;
        else if (bus.lsu_flush)   state_d = ARB_DRAIN;
        else                      state_d = ARB_BUSY_LSU;
      end

      ARB_BUSY_LSU: begin
        wd_en = 1'b1;
        // A completion beats expiry; a flush in the completion cycle
        // still suppresses the data-valid strobe.
        if (bus.mem_rdata_valid) begin
          bus.lsu_rdata_valid = !bus.lsu_flush;
          state_d             = ARB_IDLE;
        end else if (wd_expire) begin
          bus.bus_err = 1'b1;
          state_d     = ARB_IDLE;
        end else if (bus.lsu_flush) begin
          state_d = ARB_DRAIN;
        end
      end

      ARB_BUSY_AMO: begin
        wd_en = 1'b1;
        if (bus.mem_rdata_valid) begin
          bus.amo_rdata_valid = 1'b1;
          state_d             = ARB_IDLE;
        end else if (wd_expire) begin
          bus.bus_err = 1'b1;
          state_d     = ARB_IDLE;
        end
      end

      ARB_DRAIN: begin
        // Count keeps running from the busy phase; the response is dropped.
        wd_en = 1'b1;
        if (bus.mem_rdata_valid) begin
          state_d = ARB_IDLE;
        end else if (wd_expire) begin
          bus.bus_err = 1'b1;
          state_d     = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_rlen = rlen_q;
endmodule
